pu_seq: RTL
===========

# pu_seq

Multi-cycle control sequencer for the 16-bit processing unit.
- Fetches each instruction over a request/acknowledge handshake and holds it in an instruction register that feeds the decoder.
- Turns the decoder's level outputs (`h`, `we`, `pcwe`, `dmwe`, `dms`) into one-cycle commit strobes for the register file, PC and data memory.
- Supports free-run and single-step execution, a bounded memory-wait timeout, and a retired-instruction counter.

## Interface
Parameters:
- WAITMAX, 15: maximum cycles `ireq`/`dreq` may stay high without an acknowledge before a timeout fault.
- CW, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = free-run, 0 = stop after the current instruction.
- step  in  1  one-cycle pulse; executes exactly one instruction from IDLE.
- ireq  out  1  instruction fetch request.
- iack  in  1  fetch acknowledge; `idata` is valid in the same cycle.
- idata  in  16  instruction word from instruction memory.
- ir  out  16  instruction register; feeds decoder input `o`.
- h, we, pcwe, dmwe, dms  in  1 each  decoder outputs for the current `ir`.
- dreq  out  1  data memory request.
- dwr  out  1  1 = store, 0 = load; valid while `dreq` is high.
- dack  in  1  data memory acknowledge.
- rf_we  out  1  register-file write strobe.
- pc_we  out  1  PC load strobe (branch or jump taken).
- pc_inc  out  1  PC increment strobe.
- halted  out  1  HALT executed or timeout; sticky.
- fault  out  1  timeout occurred; sticky.
- busy  out  1  high in every state except IDLE and HALT.
- icnt  out  CW  retired-instruction count.

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, HALT.
- IDLE: all strobes low.
  - `run`=1 or `step`=1 → FETCH.
  - `run` and `step` both high → FETCH; behaviour is identical.
- FETCH: `ireq`=1.
  - On a cycle with `iack`=1: `ir` <= `idata`, → EXEC.
- EXEC: one cycle; decoder outputs are stable. Checks in priority order:
  - `h`=1 → HALT. No strobe fires and `icnt` does not increment.
  - Else `dmwe`|`dms` → MEM.
  - Else → WB.
- MEM: `dreq`=1, `dwr`=`dmwe`.
  - On a cycle with `dack`=1 → WB.
  - `dmwe` and `dms` both high is treated as a store.
- WB: one cycle, commit point.
  - `rf_we`=`we`.
  - `pc_we`=`pcwe`.
  - `pc_inc`=~`pcwe`.
  - `icnt` increments, wrapping modulo 2^CW.
  - Next state: `run`=1 → FETCH, else → IDLE. `step` is ignored in WB.
- HALT: `halted`=1, absorbing. Only `rst` exits.
- Wait counter (4 bits at the default WAITMAX):
  - Clears on every entry to FETCH or MEM.
  - Increments each cycle the request is high without an acknowledge.
  - On reaching WAITMAX with no acknowledge: `fault`=1, `halted`=1, → HALT. No commit.
  - An acknowledge in the same cycle the count reaches WAITMAX wins: normal progress, no fault.
- `ir` changes only on a FETCH acknowledge and holds through EXEC, MEM, WB and HALT.

## Timing
- Reset, asynchronous and immediate:
  - state = IDLE.
  - `ir`, `icnt` and the wait counter = 0.
  - `halted` and `fault` = 0.
  - All requests and strobes = 0.
- Reset asserted mid-MEM drops `dreq` immediately and no commit occurs.
- All outputs are registered state or decoded from state only; no combinational path from `iack`/`dack` to outputs.
- Latency from FETCH entry to WB, with zero-wait acknowledges:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, WB).
  - Memory instruction: 4 cycles (FETCH, EXEC, MEM, WB).
- Each wait cycle adds 1.
- In free-run, back-to-back instructions have one WB→FETCH transition with no bubble.
- `ireq`/`dreq` fall in the cycle after the acknowledge is sampled.
- Strobes are exactly one cycle wide, and only in WB.
- `busy` rises the cycle after a `step`/`run` is sampled in IDLE.

## Test plan
- Reset then `run`=1; fetch an ALU op with `we`=1, `iack` immediate → `rf_we` and `pc_inc` pulse in cycle 3, `icnt`=1, next cycle FETCH.
- `step` pulse with `run`=0; fetch a branch with `pcwe`=1 → `pc_we`=1, `pc_inc`=0 in WB, then IDLE, `busy`=0, `icnt`=1.
- Store (`dmwe`=1) with `dack` delayed 3 cycles → `dreq`=`dwr`=1 for 4 cycles, WB in cycle 7, `rf_we`=0.
- HALT word (`h`=1) → HALT after EXEC, `halted`=1, `icnt` unchanged, no strobes, stays put with `run`=1 for 20 cycles.
- `iack` held low → `fault`=`halted`=1 after 15 request cycles. Repeat with `iack` on the 15th cycle → no fault.
- Assert `rst` during MEM wait → `dreq`=0 and state IDLE immediately. Preload `icnt`=0xFFFF via 65535 runs, then one more instruction → `icnt` wraps to 0.

Source files
------------

// File: rtl/pu_seq.sv
// pu_seq: multi-cycle control sequencer (FETCH/EXEC/MEM/WB) for the 16-bit processing unit.
// Every output is a register updated alongside the state, so no acknowledge input reaches an output combinationally.
module pu_seq #(
   parameter int WAITMAX = 15,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          step,
   output logic          ireq,
   input  logic          iack,
   input  logic [15:0]   idata,
   output logic [15:0]   ir,
   input  logic          h,
   input  logic          we,
   input  logic          pcwe,
   input  logic          dmwe,
   input  logic          dms,
   output logic          dreq,
   output logic          dwr,
   input  logic          dack,
   output logic          rf_we,
   output logic          pc_we,
   output logic          pc_inc,
   output logic          halted,
   output logic          fault,
   output logic          busy,
   output logic [CW-1:0] icnt
);

   localparam int            WW    = $clog2(WAITMAX + 1);
   localparam logic [WW-1:0] WLAST = WW'(WAITMAX - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t        state;
   logic [WW-1:0] wcnt;

   // Sequencer: state, request lines, commit strobes, wait counter and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         wcnt   <= '0;
         ir     <= 16'h0000;
         icnt   <= '0;
         ireq   <= 1'b0;
         dreq   <= 1'b0;
         dwr    <= 1'b0;
         rf_we  <= 1'b0;
         pc_we  <= 1'b0;
         pc_inc <= 1'b0;
         halted <= 1'b0;
         fault  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         rf_we  <= 1'b0;
         pc_we  <= 1'b0;
         pc_inc <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run || step) begin
                  state <= S_FETCH;
                  ireq  <= 1'b1;
                  busy  <= 1'b1;
                  wcnt  <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_FETCH: begin
               // an acknowledge on the last allowed cycle still wins over the timeout
               if (iack) begin
                  ir    <= idata;
                  ireq  <= 1'b0;
                  state <= S_EXEC;
               end else if (wcnt == WLAST) begin
                  ireq   <= 1'b0;
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  fault  <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            S_EXEC: begin
               if (h) begin
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (dmwe || dms) begin
                  dreq  <= 1'b1;
                  dwr   <= dmwe;
                  wcnt  <= '0;
                  state <= S_MEM;
               end else begin
                  rf_we  <= we;
                  pc_we  <= pcwe;
                  pc_inc <= ~pcwe;
                  icnt   <= icnt + CW'(1);
                  state  <= S_WB;
               end
            end
            S_MEM: begin
               if (dack) begin
                  dreq   <= 1'b0;
                  dwr    <= 1'b0;
                  rf_we  <= we;
                  pc_we  <= pcwe;
                  pc_inc <= ~pcwe;
                  icnt   <= icnt + CW'(1);
                  state  <= S_WB;
               end else if (wcnt == WLAST) begin
                  dreq   <= 1'b0;
                  dwr    <= 1'b0;
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  fault  <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            S_WB: begin
               if (run) begin
                  ireq  <= 1'b1;
                  wcnt  <= '0;
                  state <= S_FETCH;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               ireq  <= 1'b0;
               dreq  <= 1'b0;
               dwr   <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
